// File: rtl/bcd_counter_pkg.sv
// Shared types and constants for the BCD game counter: FSM state encoding,
// BCD digit limit and default prescaler reloads.
package bcd_counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Reloads for a 50 MHz clock: 1 Hz, 2 Hz, 2.5 Hz, 4 Hz.
  localparam int DEF_DIV0 = 49_999_999;
  localparam int DEF_DIV1 = 24_999_999;
  localparam int DEF_DIV2 = 19_999_999;
  localparam int DEF_DIV3 = 12_499_999;

  function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the game counter. Steps when the chain carry reaches it;
// carry_out flags that this digit (and every lower one) sits at its limit.
module bcd_digit
  import bcd_counter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       step,
  input  logic       dir,
  input  logic       carry_in,
  output logic [3:0] value,
  output logic       carry_out
);

  logic [3:0] value_q;
  logic [3:0] value_d;
  logic       at_limit;

  always_comb begin
    at_limit  = dir ? (value_q == 4'd0) : (value_q == BCD_MAX);
    carry_out = carry_in & at_limit;
    value_d   = value_q;
    if (load) begin
      value_d = bcd_clamp(load_val);
    end else if (step && carry_in) begin
      if (dir) begin
        value_d = (value_q == 4'd0) ? BCD_MAX : value_q - 4'd1;
      end else begin
        value_d = (value_q >= BCD_MAX) ? 4'd0 : value_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= 4'd0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/bcd_game_counter.sv
// N-digit BCD game counter with tick prescaler, speed select, up/down, pause and DONE.
// Build option: BCD_COUNTER_SAT_EN makes up mode saturate at all-9s and enter DONE.
module bcd_game_counter
  import bcd_counter_pkg::*;
#(
  parameter int               DIGITS = 2,
  parameter int               DIV_W  = 28,
  parameter logic [DIV_W-1:0] DIV0   = DIV_W'(DEF_DIV0),
  parameter logic [DIV_W-1:0] DIV1   = DIV_W'(DEF_DIV1),
  parameter logic [DIV_W-1:0] DIV2   = DIV_W'(DEF_DIV2),
  parameter logic [DIV_W-1:0] DIV3   = DIV_W'(DEF_DIV3)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                pause,
  input  logic                clear,
  input  logic                mode,
  input  logic [1:0]          speed,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] count,
  output logic                tick,
  output logic                running,
  output logic                done
);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic             tick_q, tick_d;
  logic             done_q, done_d;
  logic             running_q, running_d;
  logic [DIV_W-1:0] div_sel;
  logic             load;
  logic             step;
  logic             at_end;
  logic [DIGITS:0]  carry;

  assign carry[0] = 1'b1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .clk       (clk),
      .rst       (reset),
      .load      (load),
      .load_val  (load_val[4*i +: 4]),
      .step      (step),
      .dir       (mode),
      .carry_in  (carry[i]),
      .value     (count[4*i +: 4]),
      .carry_out (carry[i+1])
    );
  end

  // carry[DIGITS] means every digit sits at its limit for the current direction.
`ifdef BCD_COUNTER_SAT_EN
  assign at_end = carry[DIGITS];
`else
  assign at_end = mode & carry[DIGITS];
`endif

  always_comb begin
    case (speed)
      2'd0:    div_sel = DIV0;
      2'd1:    div_sel = DIV1;
      2'd2:    div_sel = DIV2;
      default: div_sel = DIV3;
    endcase
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    tick_d  = 1'b0;
    done_d  = done_q;
    load    = 1'b0;
    step    = 1'b0;
    if (clear) begin
      load    = 1'b1;
      presc_d = '0;
      state_d = ST_IDLE;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && !pause) begin
            state_d = ST_RUN;
            presc_d = div_sel;
          end
        end
        // Releasing pause counts as a normal RUN edge, so the remainder resumes seamlessly.
        ST_RUN, ST_PAUSED: begin
          if (pause) begin
            state_d = ST_PAUSED;
          end else begin
            state_d = ST_RUN;
            if (presc_q == '0) begin
              presc_d = div_sel;
              tick_d  = 1'b1;
              if (at_end) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
                presc_d = '0;
              end else begin
                step = 1'b1;
              end
            end else begin
              presc_d = presc_q - DIV_W'(1);
            end
          end
        end
        ST_DONE: begin
          presc_d = '0;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    running_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      presc_q   <= '0;
      tick_q    <= 1'b0;
      done_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      tick_q    <= tick_d;
      done_q    <= done_d;
      running_q <= running_d;
    end
  end

  assign tick    = tick_q;
  assign done    = done_q;
  assign running = running_q;

endmodule
